// File: rtl/count_seq_pkg.sv
// Shared state encoding and default widths for count_sequencer and its interval counter.
package count_seq_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned REP_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/seq_counter16.sv
// Interval counter with synchronous clear and enable; match is registered and tracks
// whether the value just loaded equals cmp_val.
module seq_counter16 #(
  parameter int unsigned CNT_W = count_seq_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             ena,
  input  logic [CNT_W-1:0] cmp_val,
  output logic [CNT_W-1:0] count,
  output logic             match
);
  import count_seq_pkg::*;

  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count;
    if (clr) begin
      count_d = '0;
    end else if (ena) begin
      count_d = count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      match <= 1'b0;
    end else begin
      count <= count_d;
      match <= (count_d == cmp_val);
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// Sequences seq_counter16 through one-shot or periodic runs with tick/done/aborted pulses.
// Define COUNT_SEQ_HOLD_EN to honour the hold input (HOLD state); otherwise hold is ignored.
module count_sequencer #(
  parameter int unsigned CNT_W = count_seq_pkg::CNT_W,
  parameter int unsigned REP_W = count_seq_pkg::REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic [CNT_W-1:0] period,
  input  logic [REP_W-1:0] repeats,
  input  logic             mode_periodic,
  output logic             busy,
  output logic             cnt_ena,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             done,
  output logic             aborted,
  output logic [REP_W-1:0] run_cnt
);
  import count_seq_pkg::*;

  state_e           state_q, state_d, cont_state;
  logic [CNT_W-1:0] period_q, period_d;
  logic [REP_W-1:0] repeats_q, repeats_d;
  logic             periodic_q, periodic_d;
  logic [REP_W-1:0] run_cnt_d, run_cnt_inc;
  logic [REP_W:0]   rep_eff, run_next;
  logic             tick_d, done_d, aborted_d;
  logic             load, clr, advance, match;
  logic [CNT_W-1:0] cmp_val;

`ifdef COUNT_SEQ_HOLD_EN
  // A wrap already due in RUN still completes even if hold arrives on that cycle.
  assign advance    = (state_q == StRun || state_q == StHold) &&
                      (!hold || (state_q == StRun && match));
  assign cont_state = hold ? StHold : StRun;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign advance     = (state_q == StRun);
  assign cont_state  = StRun;
`endif

  // Compare value must reflect the new period on the very edge it is latched.
  assign cmp_val     = load ? (period - 1'b1) : (period_q - 1'b1);
  assign run_cnt_inc = (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
  assign rep_eff     = (repeats_q == '0) ? (REP_W+1)'(1) : {1'b0, repeats_q};
  assign run_next    = {1'b0, run_cnt} + 1'b1;

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    repeats_d  = repeats_q;
    periodic_d = periodic_q;
    run_cnt_d  = run_cnt;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    load       = 1'b0;
    clr        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          load       = 1'b1;
          clr        = 1'b1;
          state_d    = StRun;
          period_d   = period;
          repeats_d  = repeats;
          periodic_d = mode_periodic;
          run_cnt_d  = '0;
        end
      end
      StRun, StHold: begin
        if (stop) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
          clr       = 1'b1;
        end else if (advance && match) begin
          clr       = 1'b1;
          tick_d    = 1'b1;
          run_cnt_d = run_cnt_inc;
          if (!periodic_q && run_next == rep_eff) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = cont_state;
          end
        end else begin
          state_d = cont_state;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      period_q   <= '0;
      repeats_q  <= '0;
      periodic_q <= 1'b0;
      run_cnt    <= '0;
      tick       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      busy       <= 1'b0;
      cnt_ena    <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      repeats_q  <= repeats_d;
      periodic_q <= periodic_d;
      run_cnt    <= run_cnt_d;
      tick       <= tick_d;
      done       <= done_d;
      aborted    <= aborted_d;
      busy       <= (state_d == StRun) || (state_d == StHold);
      cnt_ena    <= (state_d == StRun);
    end
  end

  seq_counter16 #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .ena    (advance && !stop),
    .cmp_val(cmp_val),
    .count  (count),
    .match  (match)
  );

endmodule
